// File: rtl/estu_inference_scheduler.sv
// Launch sequencer for the ESTU accelerator: periodic or single-shot starts, run watchdog,
// and a small FIFO that captures last-layer results and acknowledges each valid flag.
module estu_inference_scheduler #(
    parameter int DIM_NUM_INSTR = 8,
    parameter int DIM_RESULT    = 13,
    parameter int PERIOD_WIDTH  = 24,
    parameter int TIMEOUT_WIDTH = 20,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                             i_wb_clk,
    input  logic                             i_wb_rst,
    input  logic                             i_enable,
    input  logic                             i_single_shot,
    input  logic [PERIOD_WIDTH-1:0]          i_period,
    input  logic [TIMEOUT_WIDTH-1:0]         i_timeout,
    input  logic [DIM_NUM_INSTR-1:0]         i_num_instr,
    output logic                             o_start_inference,
    output logic [DIM_NUM_INSTR-1:0]         o_num_instr,
    input  logic                             i_clr_start_inf,
    input  logic                             i_valid_last_layer,
    input  logic [DIM_RESULT-1:0]            i_data_last_layer,
    output logic                             o_clr_valid_ll,
    input  logic                             i_rd_en,
    output logic [DIM_RESULT-1:0]            o_rd_data,
    output logic                             o_rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]      o_fifo_count,
    output logic                             o_busy,
    output logic                             o_overrun,
    output logic                             o_timeout,
    input  logic                             i_clr_status,
    output logic [15:0]                      o_inf_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     state_reg;
    logic [PERIOD_WIDTH-1:0]    period_cnt_reg;
    logic [TIMEOUT_WIDTH-1:0]   wdog_reg;
    logic                       start_reg;
    logic [DIM_NUM_INSTR-1:0]   num_instr_reg;
    logic [15:0]                inf_count_reg;
    logic                       timeout_reg;
    logic                       overrun_reg;
    logic                       clr_valid_reg;
    logic [DIM_RESULT-1:0]      rd_data_reg;
    logic                       rd_valid_reg;
    logic [AW-1:0]              wr_ptr_reg;
    logic [AW-1:0]              rd_ptr_reg;
    logic [CW-1:0]              count_reg;
    logic [DIM_RESULT-1:0]      mem [0:FIFO_DEPTH-1];

    logic [PERIOD_WIDTH-1:0]    period_next;
    logic [TIMEOUT_WIDTH:0]     wdog_next;
    logic                       launch;
    logic                       wdog_hit;
    logic                       timeout_evt;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       do_push;
    logic                       do_pop;
    logic                       overrun_evt;

    // Comparisons use the post-increment value so launches land exactly i_period edges
    // apart and the watchdog aborts exactly i_timeout edges after the start edge.
    assign period_next = (&period_cnt_reg) ? period_cnt_reg : period_cnt_reg + PERIOD_WIDTH'(1);
    assign wdog_next   = {1'b0, wdog_reg} + (TIMEOUT_WIDTH + 1)'(1);
    assign launch      = (state_reg == S_IDLE) &&
                         ((i_enable && (period_next >= i_period)) || i_single_shot);
    assign wdog_hit    = (i_timeout != '0) && (wdog_next >= {1'b0, i_timeout});
    assign timeout_evt = (state_reg == S_RUN) && !i_clr_start_inf && wdog_hit;

    assign fifo_full   = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty  = (count_reg == '0);
    assign do_pop      = i_rd_en && !fifo_empty;
    assign do_push     = i_valid_last_layer && (!fifo_full || do_pop);
    assign overrun_evt = i_valid_last_layer && fifo_full && !do_pop;

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_reg      <= S_IDLE;
            period_cnt_reg <= '1;
            wdog_reg       <= '0;
            start_reg      <= 1'b0;
            num_instr_reg  <= '0;
            inf_count_reg  <= '0;
            timeout_reg    <= 1'b0;
        end else begin
            period_cnt_reg <= launch ? '0 : period_next;
            case (state_reg)
                S_IDLE: begin
                    if (launch) begin
                        state_reg     <= S_RUN;
                        start_reg     <= 1'b1;
                        num_instr_reg <= i_num_instr;
                        wdog_reg      <= '0;
                    end
                end
                S_RUN: begin
                    wdog_reg <= wdog_next[TIMEOUT_WIDTH-1:0];
                    if (i_clr_start_inf) begin
                        state_reg     <= S_DONE;
                        start_reg     <= 1'b0;
                        inf_count_reg <= inf_count_reg + 16'd1;
                    end else if (wdog_hit) begin
                        state_reg <= S_DONE;
                        start_reg <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
            if (timeout_evt)
                timeout_reg <= 1'b1;
            else if (i_clr_status)
                timeout_reg <= 1'b0;
        end
    end

    // Storage array has no reset so it can map onto block RAM; a reset only flushes pointers.
    always_ff @(posedge i_wb_clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= i_data_last_layer;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            clr_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            clr_valid_reg <= i_valid_last_layer;
            rd_valid_reg  <= do_pop;
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop) begin
                rd_data_reg <= mem[rd_ptr_reg];
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
            if (overrun_evt)
                overrun_reg <= 1'b1;
            else if (i_clr_status)
                overrun_reg <= 1'b0;
        end
    end

    assign o_start_inference = start_reg;
    assign o_num_instr       = num_instr_reg;
    assign o_clr_valid_ll    = clr_valid_reg;
    assign o_rd_data         = rd_data_reg;
    assign o_rd_valid        = rd_valid_reg;
    assign o_fifo_count      = count_reg;
    assign o_busy            = (state_reg != S_IDLE);
    assign o_overrun         = overrun_reg;
    assign o_timeout         = timeout_reg;
    assign o_inf_count       = inf_count_reg;

endmodule

// File: tb/tb_estu_inference_scheduler.sv
// Directed bench for estu_inference_scheduler: inputs change on the falling edge,
// outputs are checked on the following falling edge.
module tb_estu_inference_scheduler;
    localparam int DNI = 8;
    localparam int DR  = 13;
    localparam int PW  = 24;
    localparam int TW  = 20;
    localparam int FD  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_enable, i_single_shot, i_clr_start_inf, i_valid_last_layer;
    logic           i_rd_en, i_clr_status;
    logic [PW-1:0]  i_period;
    logic [TW-1:0]  i_timeout;
    logic [DNI-1:0] i_num_instr;
    logic [DR-1:0]  i_data_last_layer;
    logic           o_start_inference, o_clr_valid_ll, o_rd_valid, o_busy, o_overrun, o_timeout;
    logic [DNI-1:0] o_num_instr;
    logic [DR-1:0]  o_rd_data;
    logic [$clog2(FD):0] o_fifo_count;
    logic [15:0]    o_inf_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    estu_inference_scheduler #(
        .DIM_NUM_INSTR(DNI), .DIM_RESULT(DR), .PERIOD_WIDTH(PW),
        .TIMEOUT_WIDTH(TW), .FIFO_DEPTH(FD)
    ) dut (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_enable(i_enable), .i_single_shot(i_single_shot),
        .i_period(i_period), .i_timeout(i_timeout), .i_num_instr(i_num_instr),
        .o_start_inference(o_start_inference), .o_num_instr(o_num_instr),
        .i_clr_start_inf(i_clr_start_inf), .i_valid_last_layer(i_valid_last_layer),
        .i_data_last_layer(i_data_last_layer), .o_clr_valid_ll(o_clr_valid_ll),
        .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_fifo_count(o_fifo_count), .o_busy(o_busy), .o_overrun(o_overrun),
        .o_timeout(o_timeout), .i_clr_status(i_clr_status), .o_inf_count(o_inf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nedge(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int high;
        int nclr;
        int nr;
        int rises[5];
        logic prev;
        logic done;

        rst = 1'b1;
        i_enable = 1'b0; i_single_shot = 1'b0; i_clr_start_inf = 1'b0;
        i_valid_last_layer = 1'b0; i_rd_en = 1'b0; i_clr_status = 1'b0;
        i_period = '0; i_timeout = '0; i_num_instr = '0; i_data_last_layer = '0;
        nedge(2);
        chk("rst_start", 32'(o_start_inference), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_count", 32'(o_fifo_count), 32'd0);
        chk("rst_inf", 32'(o_inf_count), 32'd0);
        chk("rst_flags", {29'd0, o_overrun, o_timeout, o_rd_valid}, 32'd0);
        chk("rst_clrv", 32'(o_clr_valid_ll), 32'd0);
        rst = 1'b0;
        nedge(1);

        // Single shot, a second request during RUN is dropped.
        i_num_instr = 8'h2A; i_single_shot = 1'b1;
        nedge(1);
        i_single_shot = 1'b0; i_num_instr = 8'h55;
        chk("ss_start", 32'(o_start_inference), 32'd1);
        chk("ss_busy", 32'(o_busy), 32'd1);
        chk("ss_num", 32'(o_num_instr), 32'h2A);
        nedge(3);
        i_single_shot = 1'b1;
        nedge(1);
        i_single_shot = 1'b0;
        nedge(2);
        chk("ss_num_hold", 32'(o_num_instr), 32'h2A);
        i_clr_start_inf = 1'b1;
        nedge(1);
        i_clr_start_inf = 1'b0;
        chk("ss_done_start", 32'(o_start_inference), 32'd0);
        chk("ss_done_busy", 32'(o_busy), 32'd1);
        nedge(1);
        chk("ss_idle_busy", 32'(o_busy), 32'd0);
        chk("ss_inf", 32'(o_inf_count), 32'd1);
        nedge(3);
        chk("ss_not_queued", 32'(o_start_inference), 32'd0);

        // Watchdog abort after 50 cycles.
        i_timeout = TW'(50); i_single_shot = 1'b1;
        nedge(1);
        i_single_shot = 1'b0;
        high = 0;
        for (int i = 0; i < 200 && o_start_inference; i++) begin
            high++;
            nedge(1);
        end
        chk("wd_high_cycles", 32'(high), 32'd50);
        chk("wd_flag", 32'(o_timeout), 32'd1);
        chk("wd_inf", 32'(o_inf_count), 32'd1);
        i_clr_status = 1'b1;
        nedge(1);
        i_clr_status = 1'b0;
        chk("wd_flag_clr", 32'(o_timeout), 32'd0);
        i_timeout = '0;

        // Periodic launches every 100 cycles; the model clears 40 cycles after each start.
        i_period = PW'(100); i_enable = 1'b1;
        nr = 0; prev = o_start_inference; done = 1'b0;
        for (int cyc = 0; cyc < 1200 && !done; cyc++) begin
            if (o_start_inference && !prev && nr < 5) begin
                rises[nr] = cyc;
                nr++;
            end
            prev = o_start_inference;
            i_clr_start_inf = (nr > 0) && (cyc == rises[nr-1] + 40);
            if (nr == 5 && i_clr_start_inf) begin
                i_enable = 1'b0;
                done = 1'b1;
            end
            nedge(1);
        end
        i_clr_start_inf = 1'b0;
        chk("per_runs", 32'(nr), 32'd5);
        for (int k = 1; k < 5; k++)
            chk($sformatf("per_gap%0d", k), 32'(rises[k] - rises[k-1]), 32'd100);
        nedge(2);
        chk("per_inf", 32'(o_inf_count), 32'd6);
        nedge(120);
        chk("per_stopped", 32'(o_start_inference), 32'd0);

        // Overrun: nine pushes into an 8-deep FIFO.
        nclr = 0;
        for (int i = 1; i <= 9; i++) begin
            i_valid_last_layer = 1'b1; i_data_last_layer = DR'(i);
            nedge(1);
            nclr += int'(o_clr_valid_ll);
        end
        i_valid_last_layer = 1'b0;
        nedge(1);
        nclr += int'(o_clr_valid_ll);
        chk("ovr_clr_pulses", 32'(nclr), 32'd9);
        chk("ovr_count", 32'(o_fifo_count), 32'd8);
        chk("ovr_flag", 32'(o_overrun), 32'd1);
        i_rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            nedge(1);
            chk($sformatf("ovr_rd%0d", i), {o_rd_valid, 18'd0, o_rd_data}, {1'b1, 18'd0, DR'(i)});
        end
        nedge(1);
        i_rd_en = 1'b0;
        chk("empty_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("empty_rd_hold", 32'(o_rd_data), 32'd8);
        i_clr_status = 1'b1;
        nedge(1);
        i_clr_status = 1'b0;
        chk("ovr_flag_clr", 32'(o_overrun), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) begin
            i_valid_last_layer = 1'b1; i_data_last_layer = DR'(32'h100 + i);
            nedge(1);
        end
        i_data_last_layer = 13'h1ABC; i_rd_en = 1'b1;
        nedge(1);
        i_valid_last_layer = 1'b0;
        chk("fp_rd_data", {o_rd_valid, 18'd0, o_rd_data}, {1'b1, 18'd0, 13'h100});
        chk("fp_count", 32'(o_fifo_count), 32'd8);
        chk("fp_overrun", 32'(o_overrun), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            nedge(1);
            chk($sformatf("fp_rd%0d", i), 32'(o_rd_data), (i < 8) ? 32'h100 + i : 32'h1ABC);
        end
        i_rd_en = 1'b0;
        nedge(1);
        chk("fp_empty", 32'(o_fifo_count), 32'd0);

        // Asynchronous reset during RUN with three stored entries.
        for (int i = 0; i < 3; i++) begin
            i_valid_last_layer = 1'b1; i_data_last_layer = DR'(32'h20 + i);
            nedge(1);
        end
        i_valid_last_layer = 1'b0; i_single_shot = 1'b1;
        nedge(1);
        i_single_shot = 1'b0;
        chk("ar_pre_start", 32'(o_start_inference), 32'd1);
        chk("ar_pre_count", 32'(o_fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_start", 32'(o_start_inference), 32'd0);
        chk("ar_count", 32'(o_fifo_count), 32'd0);
        chk("ar_busy", 32'(o_busy), 32'd0);
        nedge(1);
        rst = 1'b0;
        nedge(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/estu_inference_scheduler.md
# estu_inference_scheduler

Hardware sequencer that replaces firmware polling of the ESTU accelerator's start/valid handshake. It launches inferences either periodically (programmable cycle period) or on single-shot request, and supervises each run with a watchdog. It captures every valid last-layer result into a small FIFO and clears the accelerator's valid flag. It sits between the memory-mapped register block and the `estu` instance, driving `i_start_inference`, `num_instr` and `i_clr_valid_ll_ext`.

## Interface
Parameters:
- DIM_NUM_INSTR, 8, width of the instruction-count field forwarded to ESTU
- DIM_RESULT, 13, width of last-layer result word
- PERIOD_WIDTH, 24, width of launch-period counter
- TIMEOUT_WIDTH, 20, width of watchdog counter
- FIFO_DEPTH, 8, result FIFO entries (power of 2, ≥2)

Ports:
- i_wb_clk  in  1  clock; single clock domain
- i_wb_rst  in  1  reset; asynchronous, active-high
- i_enable  in  1  periodic launching enabled
- i_single_shot  in  1  one-cycle pulse; request one inference
- i_period  in  PERIOD_WIDTH  minimum cycles between launches
- i_timeout  in  TIMEOUT_WIDTH  watchdog limit in cycles; 0 disables
- i_num_instr  in  DIM_NUM_INSTR  instruction count, latched at launch
- o_start_inference  out  1  level to ESTU start input
- o_num_instr  out  DIM_NUM_INSTR  latched instruction count to ESTU
- i_clr_start_inf  in  1  ESTU pulse: inference complete
- i_valid_last_layer  in  1  ESTU pulse: result valid
- i_data_last_layer  in  DIM_RESULT  ESTU result word
- o_clr_valid_ll  out  1  one-cycle clear pulse to ESTU
- i_rd_en  in  1  FIFO pop request
- o_rd_data  out  DIM_RESULT  popped result (registered)
- o_rd_valid  out  1  o_rd_data valid this cycle
- o_fifo_count  out  clog2(FIFO_DEPTH)+1  entries held
- o_busy  out  1  state ≠ IDLE
- o_overrun  out  1  sticky: result dropped, FIFO full
- o_timeout  out  1  sticky: watchdog abort occurred
- i_clr_status  in  1  clears o_overrun and o_timeout
- o_inf_count  out  16  completed inferences, wraps 0xFFFF→0

## Operation
- Reset: state IDLE; all outputs 0; period counter saturated to all-ones, so the first enabled launch is immediate; FIFO empty.
- Period counter: saturating up-counter; cleared to 0 on every launch.
- States:
  - IDLE: launch if (i_enable & cnt ≥ i_period) | i_single_shot → RUN. On launch, latch i_num_instr into o_num_instr, set o_start_inference=1, clear the watchdog.
  - RUN: o_start_inference held 1; the watchdog increments each cycle.
    - i_clr_start_inf → DONE; o_start_inference=0; o_inf_count+1.
    - Watchdog reaching i_timeout (≠0) with no clr → DONE; o_start_inference=0; o_timeout set; o_inf_count unchanged.
    - i_clr_start_inf and timeout in the same cycle: completion wins; no timeout flag.
  - DONE: one cycle, then → IDLE. This guarantees o_start_inference is low for at least one cycle between runs.
- Result capture in any state: i_valid_last_layer pushes i_data_last_layer and asserts o_clr_valid_ll the next cycle, exactly one pulse per valid. Valid pulses arriving on consecutive cycles each push and each get a clear pulse.
- FIFO push behaviour:
  - Full with no pop: the word is dropped, o_overrun is set, and the clear pulse is still issued.
  - Full with a simultaneous pop: both the push and the pop happen, with no overrun.
- FIFO pop behaviour: i_rd_en on an empty FIFO is ignored, o_rd_valid stays 0, and o_rd_data holds its value.
- Deasserting i_enable during RUN does not abort the run; no further periodic launch follows.
- i_single_shot outside IDLE is dropped, not queued.
- i_period=0: back-to-back launches, each separated only by the DONE cycle.
- i_clr_status clears the sticky flags. A set event in the same cycle wins.

## Timing
- Launch decision at edge k (IDLE) → o_start_inference=1 and o_busy=1 from edge k.
- i_clr_start_inf sampled at edge k → o_start_inference=0 at k, state DONE at k, IDLE at k+1. The earliest relaunch is edge k+2.
- Watchdog: start at edge s; abort at edge s+i_timeout.
- i_valid_last_layer at edge k → entry written at k, o_fifo_count updated at k, o_clr_valid_ll high during cycle k..k+1 (registered, one cycle).
- i_rd_en at edge k (non-empty) → o_rd_data/o_rd_valid valid after k, o_rd_valid low again after k+1 unless popped again.
- Asynchronous reset mid-RUN: o_start_inference drops immediately; the FIFO is flushed.

## Test plan
- Periodic mode: i_period=100, i_enable=1, ESTU model pulses clr 40 cycles after start → start rising edges exactly 100 cycles apart, o_inf_count=5 after 5 runs.
- Single shot: i_enable=0, one i_single_shot pulse with i_num_instr=0x2A → one start, o_num_instr=0x2A, a second pulse during RUN is ignored, o_inf_count=1.
- Watchdog: i_timeout=50, ESTU never clears → o_start_inference falls 50 cycles after rising, o_timeout=1, o_inf_count=0; i_clr_status → o_timeout=0.
- FIFO overrun: 9 valid pulses carrying 1..9, no reads → count=8, o_overrun=1, nine clear pulses. Reads return 1..8 in order; a 9th read gives o_rd_valid=0.
- Full with simultaneous push and pop: FIFO holds 8, i_rd_en coincides with valid carrying 0x1ABC → o_rd_data=oldest word, count stays 8, o_overrun=0, last read returns 0x1ABC.
- Async reset asserted mid-RUN with 3 entries stored → o_start_inference=0 without a clock edge, count=0, o_busy=0.
